serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder controller. Computes a + b + cin one bit per clock,
//   LSB first, by reusing a single 1-bit full-adder cell. Operands are
//   copied on an accepted start so the inputs may change freely afterwards.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin an addition (sampled only while ready=1)
//   abort  in   cancel an addition in progress (RUN only)
//   a, b   in   WIDTH-bit operands, captured on accepted start
//   cin    in   carry-in, captured on accepted start
//   ready  out  block can accept start (IDLE)
//   busy   out  bits are being processed (RUN)
//   done   out  one-cycle pulse when sum/cout are valid
//   sum    out  WIDTH-bit result, held until the next accepted start
//   cout   out  final carry-out, held with sum
//
// State | Meaning
// IDLE  | waiting for start; ready=1
// RUN   | one bit of the sum produced per clock, LSB first; busy=1
// DONE  | result valid; done pulses for exactly one cycle

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_b_q, sum_q;
  logic             carry_q, cout_q;
  logic [CW-1:0]    bit_cnt_q;

  logic x_bit, y_bit, s_bit, c_bit;
  logic last_bit, accept, step;

  // Operand copies shift right each step, so the current bit is always at [0].
  assign x_bit    = op_a_q[0];
  assign y_bit    = op_b_q[0];
  assign s_bit    = x_bit ^ y_bit ^ carry_q;
  assign c_bit    = (x_bit & y_bit) | (x_bit & carry_q) | (y_bit & carry_q);
  assign last_bit = (bit_cnt_q == CW'(WIDTH - 1));

  assign sum  = sum_q;
  assign cout = cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // abort wins over the completion transition on the same edge
        if (abort) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (last_bit) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else if (accept) begin
      op_a_q    <= a;
      op_b_q    <= b;
      carry_q   <= cin;
      bit_cnt_q <= '0;
    end else if (step) begin
      op_a_q           <= op_a_q >> 1;
      op_b_q           <= op_b_q >> 1;
      carry_q          <= c_bit;
      sum_q[bit_cnt_q] <= s_bit;
      bit_cnt_q        <= bit_cnt_q + 1'b1;
      if (last_bit) cout_q <= c_bit;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Directed bench for serial_add_ctrl: an 8-bit instance for the hand-computed
//   vectors, ignored-start, abort and reset cases, and a 4-bit instance swept
//   over every a/b/cin combination with back-to-back starts.

module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;

  logic       start8, abort8, cin8;
  logic [7:0] a8, b8;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4, abort4, cin4;
  logic [3:0] a4, b4;
  logic       ready4, busy4, done4, cout4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
    .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .a(a4), .b(b4), .cin(cin4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with ready8=1: presents operands, holds start for one
  // edge, then scrambles the inputs so only the captured copies matter.
  task automatic launch8(input logic [7:0] a_v, input logic [7:0] b_v, input logic c_v);
    a8 = a_v; b8 = b_v; cin8 = c_v; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a_v; b8 = a_v ^ 8'h3C; cin8 = ~c_v;
  endtask

  // Entered at RUN cycle 1 (negedge after the accepting edge).
  task automatic wait_done8(input string tag, input logic [7:0] exp_sum, input logic exp_cout);
    int cyc;
    cyc = 1;
    while (!done8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, done8, 1'b1);
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_sum"}, sum8, exp_sum);
    check({tag, "_cout"}, cout8, exp_cout);
    @(negedge clk);
    check({tag, "_ready_after"}, ready8, 1'b1);
    check({tag, "_done_after"}, done8, 1'b0);
  endtask

  initial begin
    int done_cnt;
    int done_cyc;
    int wait_cnt;
    logic [4:0] exp5;

    rst_n = 1'b0;
    start8 = 0; abort8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start4 = 0; abort4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    #12;
    check("rst_ready", ready8, 1'b1);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_sum", sum8, 8'h00);
    check("rst_cout", cout8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Hand-computed vectors
    launch8(8'h00, 8'h00, 1'b0);
    check("zero_busy", busy8, 1'b1);
    check("zero_ready", ready8, 1'b0);
    wait_done8("zero", 8'h00, 1'b0);
    launch8(8'hFF, 8'h01, 1'b0);
    wait_done8("ripple", 8'h00, 1'b1);
    launch8(8'h7F, 8'h01, 1'b0);
    wait_done8("msb", 8'h80, 1'b0);
    launch8(8'hA5, 8'h5A, 1'b1);
    wait_done8("a5_5a", 8'h00, 1'b1);
    launch8(8'h3C, 8'h99, 1'b1);
    wait_done8("mixed", 8'hD6, 1'b0);

    // Result held stable in IDLE
    repeat (3) @(negedge clk);
    check("hold_sum", sum8, 8'hD6);
    check("hold_cout", cout8, 1'b0);

    // Extra starts at RUN cycle 3 and in DONE (cycle 9) are ignored
    launch8(8'h12, 8'h34, 1'b0);
    done_cnt = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (cyc == 3 || cyc == 9) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      if (done8) begin
        done_cnt++;
        done_cyc = cyc;
        check("ign_sum", sum8, 8'h46);
        check("ign_cout", cout8, 1'b0);
      end
      if (cyc == 10) check("ign_ready_after_done", ready8, 1'b1);
      if (cyc == 11) check("ign_no_queued_run", busy8, 1'b0);
      @(negedge clk);
    end
    start8 = 1'b0;
    check("ign_done_count", done_cnt, 1);
    check("ign_done_cycle", done_cyc, 9);

    // Abort at RUN cycle 4
    launch8(8'h0F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_busy_before", busy8, 1'b1);
    abort8 = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    check("abort_ready", ready8, 1'b1);
    check("abort_busy", busy8, 1'b0);
    done_cnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done8) done_cnt++;
      @(negedge clk);
    end
    check("abort_no_done", done_cnt, 0);

    // Abort in IDLE has no effect; start with abort in IDLE is accepted
    abort8 = 1'b1;
    launch8(8'h21, 8'h10, 1'b1);
    abort8 = 1'b0;
    check("abort_idle_accept", busy8, 1'b1);
    wait_done8("start_abort", 8'h32, 1'b0);

    // Reset mid-RUN at cycle 5, then start on the first edge after release
    launch8(8'hF0, 8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", ready8, 1'b1);
    check("midrst_busy", busy8, 1'b0);
    check("midrst_done", done8, 1'b0);
    check("midrst_sum", sum8, 8'h00);
    check("midrst_cout", cout8, 1'b0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done8) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    rst_n = 1'b1;
    launch8(8'hF0, 8'h0F, 1'b1);
    check("postrst_accept", busy8, 1'b1);
    wait_done8("postrst", 8'h00, 1'b1);

    // WIDTH=4 exhaustive, start held high so every ready cycle starts a new add
    start4 = 1'b1;
    for (int idx = 0; idx < 512; idx++) begin
      wait_cnt = 0;
      while (!ready4 && wait_cnt < 10) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (!ready4) begin
        check("w4_ready_timeout", ready4, 1'b1);
        break;
      end
      a4 = idx[3:0]; b4 = idx[7:4]; cin4 = idx[8];
      exp5 = {1'b0, idx[3:0]} + {1'b0, idx[7:4]} + {4'b0, idx[8]};
      @(negedge clk);
      wait_cnt = 0;
      while (!done4 && wait_cnt < 10) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (!done4) begin
        check("w4_done_timeout", done4, 1'b1);
        break;
      end
      if ({cout4, sum4} !== exp5) begin
        check($sformatf("w4_result_%0d", idx), {cout4, sum4}, exp5);
      end else begin
        checks++;
      end
      @(negedge clk);
    end
    start4 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
